// File: rtl/p2_regfile_sb_if.sv
// rtl/p2_regfile_sb_if.sv - issue, write-back, operand and debug signals of the stage-2 register file
//
// Signals:
//   rd_en, rd_addr, dst_en, dst_addr : issue request from decode (read operands, reserve destination)
//   wb_en, wb_addr, wb_data          : write-back port from stage 5
//   rd_data, rd_valid                : registered operands, valid one cycle after an accepted issue
//   stall                            : combinational hazard stall for the current issue
//   busy                             : scoreboard, bit n = write to register n pending
//   dbg_sel, dbg_data                : raw register peek, no bypass
// Modports: master drives requests (decode/write-back side), slave is the register file.
interface p2_regfile_sb_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = 3,
  parameter int NREAD = 2
);
  logic                   rd_en;
  logic [NREAD*AW-1:0]    rd_addr;
  logic                   dst_en;
  logic [AW-1:0]          dst_addr;
  logic                   wb_en;
  logic [AW-1:0]          wb_addr;
  logic [WIDTH-1:0]       wb_data;
  logic [NREAD*WIDTH-1:0] rd_data;
  logic                   rd_valid;
  logic                   stall;
  logic [NREG-1:0]        busy;
  logic [AW-1:0]          dbg_sel;
  logic [WIDTH-1:0]       dbg_data;

  modport master (
    output rd_en, rd_addr, dst_en, dst_addr, wb_en, wb_addr, wb_data, dbg_sel,
    input  rd_data, rd_valid, stall, busy, dbg_data
  );

  modport slave (
    input  rd_en, rd_addr, dst_en, dst_addr, wb_en, wb_addr, wb_data, dbg_sel,
    output rd_data, rd_valid, stall, busy, dbg_data
  );
endinterface

// File: rtl/p2_regfile_sb.sv
// rtl/p2_regfile_sb.sv - multi-port registered-read register file with write-back bypass and busy-bit scoreboard
//
// Ports:
//   clock : single clock, all state updates on rising edge
//   reset : asynchronous active-low reset, clears registers, scoreboard and read outputs
//   bus   : p2_regfile_sb_if slave modport (issue, write-back, operands, stall, busy, debug)
// Parameters: WIDTH data width, NREG registers, AW address width, NREAD read ports,
//   R0_ZERO=1 makes register 0 read as zero and ignore writes/reservations.
module p2_regfile_sb #(
  parameter int WIDTH   = 16,
  parameter int NREG    = 8,
  parameter int AW      = 3,
  parameter int NREAD   = 2,
  parameter int R0_ZERO = 0
) (
  input logic             clock,
  input logic             reset,
  p2_regfile_sb_if.slave  bus
);

  logic [WIDTH-1:0]       regs [NREG];
  logic [NREG-1:0]        busy_q;
  logic [NREAD*WIDTH-1:0] rd_data_q;
  logic                   rd_valid_q;

  logic [AW-1:0]          ra [NREAD];
  logic [NREAD-1:0]       hit;
  logic [NREAD-1:0]       rhaz;
  logic                   waw;
  logic                   stall_c;
  logic                   accept;

  // An address is architecturally real only if it is in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NREG) && !((R0_ZERO != 0) && (a == '0));
  endfunction

  // Range-safe lookups: out-of-range addresses read as zero / not busy.
  function automatic logic [WIDTH-1:0] reg_val(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int n = 0; n < NREG; n++) begin
      if (int'(a) == n && addr_ok(a)) v = regs[n];
    end
    return v;
  endfunction

  function automatic logic busy_at(input logic [AW-1:0] a);
    logic b;
    b = 1'b0;
    for (int n = 0; n < NREG; n++) begin
      if (int'(a) == n) b = busy_q[n];
    end
    return b;
  endfunction

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      ra[i] = bus.rd_addr[i*AW +: AW];
    end
  end

  // A pending write only blocks a read when write-back is not delivering it this very cycle.
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      hit[i]  = bus.wb_en && (bus.wb_addr == ra[i]) && addr_ok(ra[i]);
      rhaz[i] = addr_ok(ra[i]) && busy_at(ra[i]) && !hit[i];
    end
    waw = bus.dst_en && addr_ok(bus.dst_addr) && busy_at(bus.dst_addr) &&
          !(bus.wb_en && (bus.wb_addr == bus.dst_addr));
    // Gated by reset so stall reads low while the block is held in reset.
    stall_c = reset && bus.rd_en && ((|rhaz) || waw);
    accept  = bus.rd_en && !stall_c;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NREG; n++) begin
        regs[n] <= '0;
      end
      busy_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= accept;
      if (accept) begin
        for (int i = 0; i < NREAD; i++) begin
          rd_data_q[i*WIDTH +: WIDTH] <= hit[i] ? bus.wb_data : reg_val(ra[i]);
        end
      end
      for (int n = 0; n < NREG; n++) begin
        if (bus.wb_en && (bus.wb_addr == AW'(n)) && addr_ok(AW'(n))) begin
          regs[n] <= bus.wb_data;
        end
        // A new reservation beats the write-back of the previous writer to the same register.
        if (accept && bus.dst_en && (bus.dst_addr == AW'(n)) && addr_ok(AW'(n))) begin
          busy_q[n] <= 1'b1;
        end else if (bus.wb_en && (bus.wb_addr == AW'(n))) begin
          busy_q[n] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.dbg_data = reg_val(bus.dbg_sel);
    bus.rd_data  = rd_data_q;
    bus.rd_valid = rd_valid_q;
    bus.stall    = stall_c;
    bus.busy     = busy_q;
  end

endmodule

// File: tb/tb_p2_regfile_sb.sv
// tb/tb_p2_regfile_sb.sv - scoreboard bench for p2_regfile_sb (default config and a 32-bit/6-reg/3-port/R0-zero config)
module tb_p2_regfile_sb;
  localparam int W   = 16;
  localparam int N   = 8;
  localparam int AW  = 3;
  localparam int NR  = 2;
  localparam int WB  = 32;
  localparam int NB  = 6;
  localparam int NRB = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  p2_regfile_sb_if #(.WIDTH(W),  .NREG(N),  .AW(AW), .NREAD(NR))  bus_a ();
  p2_regfile_sb_if #(.WIDTH(WB), .NREG(NB), .AW(AW), .NREAD(NRB)) bus_b ();

  p2_regfile_sb #(.WIDTH(W), .NREG(N), .AW(AW), .NREAD(NR), .R0_ZERO(0)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a));
  p2_regfile_sb #(.WIDTH(WB), .NREG(NB), .AW(AW), .NREAD(NRB), .R0_ZERO(1)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic         stall;
    logic [15:0]  busy;
    logic         rv;
    logic [127:0] rd;
    logic [127:0] dbg;
  } cyc_t;

  cyc_t         qa_cyc[$];
  cyc_t         qb_cyc[$];
  logic [127:0] qa_data[$];
  logic [127:0] qb_data[$];
  cyc_t         ra_rec, rb_rec;

  // Reference model state, index 0 = config A, 1 = config B
  logic [31:0]  m_regs [2][8];
  logic [7:0]   m_busy [2];
  logic [127:0] m_rd [2];
  logic         m_rv [2];
  bit           last_stall [2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit ok(input int m, input int a);
    return (a < ((m == 1) ? NB : N)) && !((m == 1) && (a == 0));
  endfunction

  task automatic model_reset(input int m);
    for (int n = 0; n < 8; n++) m_regs[m][n] = '0;
    m_busy[m] = '0;
    m_rd[m] = '0;
    m_rv[m] = 1'b0;
    last_stall[m] = 1'b0;
  endtask

  // One issue cycle: drive inputs, record what the DUT must show this cycle, then advance the model over the edge.
  task automatic step(input int m, input bit en, input int a0, input int a1, input int a2,
                      input bit de, input int d, input bit we, input int wa,
                      input logic [31:0] wd_in, input int ds);
    int           aa [3];
    int           nrd, wdt, nreg;
    bit           haz, acc, h;
    logic [31:0]  mask, wd, v;
    logic [127:0] rd;
    cyc_t         rec;
    @(posedge clock);
    #1;
    aa[0] = a0; aa[1] = a1; aa[2] = a2;
    nrd  = (m == 1) ? NRB : NR;
    wdt  = (m == 1) ? WB : W;
    nreg = (m == 1) ? NB : N;
    mask = (m == 1) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    wd   = wd_in & mask;
    if (m == 0) begin
      bus_a.rd_en = en; bus_a.rd_addr = {AW'(a1), AW'(a0)};
      bus_a.dst_en = de; bus_a.dst_addr = AW'(d);
      bus_a.wb_en = we; bus_a.wb_addr = AW'(wa); bus_a.wb_data = wd[15:0];
      bus_a.dbg_sel = AW'(ds);
    end else begin
      bus_b.rd_en = en; bus_b.rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
      bus_b.dst_en = de; bus_b.dst_addr = AW'(d);
      bus_b.wb_en = we; bus_b.wb_addr = AW'(wa); bus_b.wb_data = wd;
      bus_b.dbg_sel = AW'(ds);
    end
    haz = 1'b0;
    for (int i = 0; i < nrd; i++)
      if (ok(m, aa[i]) && m_busy[m][aa[i]] && !(we && wa == aa[i])) haz = 1'b1;
    if (de && ok(m, d) && m_busy[m][d] && !(we && wa == d)) haz = 1'b1;
    haz = en && haz;
    acc = en && !haz;
    rec.stall = haz;
    rec.busy  = {8'h00, m_busy[m]};
    rec.rv    = m_rv[m];
    rec.rd    = m_rd[m];
    rec.dbg   = (ds < nreg) ? {96'h0, m_regs[m][ds]} : '0;
    if (m == 0) qa_cyc.push_back(rec); else qb_cyc.push_back(rec);
    if (acc) begin
      rd = '0;
      for (int i = 0; i < nrd; i++) begin
        h = we && (wa == aa[i]) && ok(m, aa[i]);
        v = h ? wd : (ok(m, aa[i]) ? m_regs[m][aa[i]] : 32'h0);
        rd = rd | ({96'h0, v & mask} << (i * wdt));
      end
      m_rd[m] = rd;
      m_rv[m] = 1'b1;
      if (m == 0) qa_data.push_back(rd); else qb_data.push_back(rd);
    end else begin
      m_rv[m] = 1'b0;
    end
    if (we && ok(m, wa)) m_regs[m][wa] = wd;
    if (we) m_busy[m][wa] = 1'b0;
    if (acc && de && ok(m, d)) m_busy[m][d] = 1'b1;
    last_stall[m] = haz;
  endtask

  always @(negedge clock) begin
    if (qa_cyc.size() > 0) begin
      ra_rec = qa_cyc.pop_front();
      chk("a_stall", bus_a.stall, ra_rec.stall);
      chk("a_busy", bus_a.busy, ra_rec.busy);
      chk("a_rd_valid", bus_a.rd_valid, ra_rec.rv);
      chk("a_rd_data_reg", bus_a.rd_data, ra_rec.rd);
      chk("a_dbg", bus_a.dbg_data, ra_rec.dbg);
    end
    if (reset && bus_a.rd_valid) begin
      if (qa_data.size() == 0) chk("a_unexpected_rd_valid", 1'b1, 1'b0);
      else chk("a_rd_data", bus_a.rd_data, qa_data.pop_front());
    end
  end

  always @(negedge clock) begin
    if (qb_cyc.size() > 0) begin
      rb_rec = qb_cyc.pop_front();
      chk("b_stall", bus_b.stall, rb_rec.stall);
      chk("b_busy", bus_b.busy, rb_rec.busy);
      chk("b_rd_valid", bus_b.rd_valid, rb_rec.rv);
      chk("b_rd_data_reg", bus_b.rd_data, rb_rec.rd);
      chk("b_dbg", bus_b.dbg_data, rb_rec.dbg);
    end
    if (reset && bus_b.rd_valid) begin
      if (qb_data.size() == 0) chk("b_unexpected_rd_valid", 1'b1, 1'b0);
      else chk("b_rd_data", bus_b.rd_data, qb_data.pop_front());
    end
  end

  initial begin
    bit en, de, we;
    int a0, a1, d, wa, ds;
    logic [31:0] wd;
    bus_a.rd_en = 0; bus_a.rd_addr = '0; bus_a.dst_en = 0; bus_a.dst_addr = '0;
    bus_a.wb_en = 0; bus_a.wb_addr = '0; bus_a.wb_data = '0; bus_a.dbg_sel = '0;
    bus_b.rd_en = 0; bus_b.rd_addr = '0; bus_b.dst_en = 0; bus_b.dst_addr = '0;
    bus_b.wb_en = 0; bus_b.wb_addr = '0; bus_b.wb_data = '0; bus_b.dbg_sel = '0;
    model_reset(0);
    model_reset(1);
    en = 0; de = 0; a0 = 0; a1 = 0; d = 0;

    repeat (3) @(posedge clock);
    #2;
    chk("rst_busy", bus_a.busy, 8'h00);
    chk("rst_rd_valid", bus_a.rd_valid, 1'b0);
    chk("rst_rd_data", bus_a.rd_data, 32'h0);
    chk("rst_stall", bus_a.stall, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Config B: 32-bit, 6 registers, 3 read ports, r0 hardwired to zero
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0000FFFF, 1);
    step(1, 1, 1, 1, 4, 0, 0, 0, 0, 32'h0, 0);
    step(1, 1, 0, 7, 0, 1, 0, 0, 0, 32'h0, 7);
    step(1, 1, 7, 2, 3, 1, 5, 0, 0, 32'h0, 0);
    step(1, 1, 5, 1, 0, 0, 0, 0, 0, 32'h0, 1);
    step(1, 1, 5, 1, 0, 0, 0, 1, 5, 32'h55AA55AA, 5);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 5);

    // Config A directed scenarios
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h1234, 0);
    step(0, 1, 3, 0, 0, 0, 0, 0, 0, 32'h0, 3);
    step(0, 1, 1, 1, 0, 1, 2, 0, 0, 32'h0, 0);
    step(0, 1, 2, 0, 0, 0, 0, 0, 0, 32'h0, 2);
    step(0, 1, 2, 0, 0, 0, 0, 1, 2, 32'hBEEF, 2);
    step(0, 1, 0, 0, 0, 1, 5, 0, 0, 32'h0, 5);
    step(0, 1, 0, 0, 0, 1, 5, 1, 5, 32'hAAAA, 5);
    step(0, 1, 5, 5, 0, 0, 0, 1, 5, 32'h7777, 5);

    // Randomized traffic; stalled requests are held stable until accepted
    for (int k = 0; k < 400; k++) begin
      if (!last_stall[0]) begin
        en = ($urandom % 4) != 0;
        a0 = $urandom % 8;
        a1 = $urandom % 8;
        de = $urandom % 2;
        d  = $urandom % 8;
      end
      we = ($urandom % 3) != 0;
      wa = $urandom % 8;
      if (m_busy[0] != 0 && ($urandom % 2) == 1) begin
        for (int t = 0; t < 16; t++) begin
          wa = $urandom % 8;
          if (m_busy[0][wa]) break;
        end
      end
      wd = $urandom;
      ds = $urandom % 8;
      step(0, en, a0, a1, 0, de, d, we, wa, wd, ds);
    end

    // Fill every register, then reserve all of them
    for (int n = 0; n < 8; n++) step(0, 0, 0, 0, 0, 0, 0, 1, n, 32'h1100 + n * 3, n);
    for (int n = 0; n < 8; n++) step(0, 1, n, n, 0, 1, n, 0, 0, 32'h0, n);
    @(posedge clock);
    #1;
    chk("pre_rst_busy_full", bus_a.busy, 8'hFF);
    #1;
    bus_a.rd_en = 1'b0; bus_a.dst_en = 1'b0; bus_a.wb_en = 1'b0;
    #1;
    reset = 1'b0;
    qa_data.delete();
    model_reset(0);
    #1;
    chk("midrst_busy", bus_a.busy, 8'h00);
    chk("midrst_rd_valid", bus_a.rd_valid, 1'b0);
    chk("midrst_rd_data", bus_a.rd_data, 32'h0);
    bus_a.rd_en = 1'b1;
    bus_a.rd_addr = {AW'(2), AW'(6)};
    #1;
    chk("midrst_stall", bus_a.stall, 1'b0);
    bus_a.rd_en = 1'b0;
    for (int n = 0; n < 8; n++) begin
      bus_a.dbg_sel = AW'(n);
      #1;
      chk($sformatf("midrst_reg%0d", n), bus_a.dbg_data, 16'h0);
    end
    @(negedge clock);
    reset = 1'b1;

    step(0, 1, 3, 6, 0, 1, 4, 0, 0, 32'h0, 3);
    step(0, 1, 4, 7, 0, 0, 0, 1, 4, 32'h4242, 4);
    step(0, 1, 4, 0, 0, 0, 0, 0, 0, 32'h0, 4);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);

    repeat (3) @(posedge clock);
    #1;
    chk("a_data_queue_drained", 32'(qa_data.size()), 32'd0);
    chk("b_data_queue_drained", 32'(qb_data.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/p2_regfile_sb.md
Name: p2_regfile_sb

Overview:
- Parametrised successor to the stage-2 register file. Multi-port, registered-read register file with write-back bypass and a busy-bit scoreboard for RAW/WAW hazard stalls.
- Sits between fetch and execute. Stage-2 decode drives read and destination addresses; stage-5 write-back drives the write port.
- Replaces the fixed 8x16 two-read array, whose reads and writes ran on separate clocks with no hazard detection.

Parameters:
WIDTH, 16, data width of each register
NREG, 8, number of architectural registers (2..2^AW)
AW, 3, register address width
NREAD, 2, number of read ports (1..4)
R0_ZERO, 0, 1 = register 0 hardwired to zero

Ports:
clock  in  1  single clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; low clears all state immediately
rd_en  in  1  issue request: read operands (and reserve destination)
rd_addr  in  NREAD*AW  packed read addresses, port i at [i*AW +: AW]
dst_en  in  1  issuing instruction writes a register
dst_addr  in  AW  destination register of issuing instruction
wb_en  in  1  write-back valid
wb_addr  in  AW  write-back register
wb_data  in  WIDTH  write-back value
rd_data  out  NREAD*WIDTH  registered operand values, packed like rd_addr
rd_valid  out  1  rd_data updated by an accepted issue last cycle
stall  out  1  combinational: issue blocked by hazard
busy  out  NREG  scoreboard bits, bit n = write to reg n pending
dbg_sel  in  AW  debug register select
dbg_data  out  WIDTH  combinational raw contents of reg[dbg_sel], no bypass

Behaviour:
- Reset (reset=0, async): all registers = 0, busy = 0, rd_data = 0, rd_valid = 0. stall = 0 while in reset.
- Valid address: a < NREG and not (R0_ZERO=1 and a=0).
  - Invalid-address reads return 0 and never hazard.
  - Invalid-address writes are ignored.
  - Invalid-address reservations set nothing.
- Bypass hit for address a: wb_en=1 and wb_addr=a and a valid.
- Read hazard, port i: rd_addr[i] valid, busy[rd_addr[i]]=1, and no bypass hit.
- WAW hazard: dst_en=1, dst_addr valid, busy[dst_addr]=1, and not (wb_en=1 and wb_addr=dst_addr).
- stall = rd_en and (any read hazard or WAW hazard). Purely combinational, no registered state.
- Accept = rd_en and not stall.
- On accept, next edge:
  - rd_data[i] = bypass hit ? wb_data : reg[rd_addr[i]] (0 if invalid).
  - rd_valid = 1.
- Not accepted: rd_valid = 0; rd_data holds its previous value.
- Read latency: 1 cycle from accepted issue to rd_data/rd_valid.
- Write: wb_en=1 and wb_addr valid updates reg[wb_addr] at the edge.
  - Write-back into a non-busy register is legal and still writes.
- Scoreboard update per edge, for each n:
  - set when accept, dst_en=1, dst_addr=n, n valid;
  - clear when wb_en=1, wb_addr=n;
  - set wins over clear when both hit n in the same cycle (back-to-back writers).
- Same-cycle write and read of one address: bypass supplies the new value, never the stale one.
- Two reads of the same address on different ports return identical data.
- stall is held only while the hazard persists; the requester must hold rd_en/addresses stable while stalled.
- Reset asserted mid-operation: pending reservations are discarded (busy=0), and the next issue after release sees all registers at 0.

Test Plan:
- Reset then wb_en=1, wb_addr=3, wb_data=16'h1234; next cycle issue rd_addr={3,0} -> one cycle later rd_data port0=16'h1234, port1=0, rd_valid=1.
- Issue dst_en=1, dst_addr=2 (accept) -> busy=8'b0000_0100. Next cycle issue reading r2 with wb_en=0 -> stall=1, rd_valid=0, rd_data held. Then wb r2=16'hBEEF in the same cycle as the retried read -> stall=0; rd_data=16'hBEEF the next cycle; busy[2]=0.
- busy[5]=1, issue with dst_addr=5 while wb_en=1, wb_addr=5 -> no stall, busy[5] stays 1 (set wins), reg5 = wb_data.
- R0_ZERO=1: wb r0=16'hFFFF, issue read r0 with dst_addr=0 -> rd_data=0, busy[0]=0, dbg_sel=0 gives dbg_data=0. NREG=6: read r7 -> 0, no stall.
- NREAD=3, WIDTH=32: write r1=32'hDEADBEEF, read {1,1,4} -> ports 0 and 1 return 32'hDEADBEEF, port 2 returns 0.
- Assert reset mid-run with busy=8'hFF and registers nonzero -> busy, rd_data, rd_valid, and all registers (via dbg_data) read 0 immediately, without a clock edge.
